// File: rtl/bcd_uart_pkg.sv
// Shared definitions for the 3-digit BCD serial link: ASCII codes, message FSM states
// and the nibble-to-ASCII helper. Used by both the transmitter and the receiver.
package bcd_uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  // Non-decimal nibbles are reported as '?' so a corrupted digit is visible on the line.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] nibble);
    logic [7:0] code;
    if (nibble <= 4'd9) begin
      code = ASCII_ZERO + {4'd0, nibble};
    end else begin
      code = ASCII_ERR;
    end
    return code;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serialiser: start bit, 8 data bits LSB first, stop bit.
// frame_done marks the last clock of the stop bit so a new load can follow with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       frame_done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      STOP_BIT = 4'd9;

  logic             active_r;
  logic [7:0]       shift_r;
  logic [CNT_W-1:0] baud_r;
  logic [3:0]       bit_r;
  logic             tx_r;

  assign tx         = tx_r;
  assign frame_done = active_r && (bit_r == STOP_BIT) && (baud_r == CNT_LAST);

  // Frame sequencer: load has priority so the next frame starts on the edge the current one ends.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_r <= 1'b0;
      shift_r  <= 8'h00;
      baud_r   <= {CNT_W{1'b0}};
      bit_r    <= 4'd0;
      tx_r     <= 1'b1;
    end else if (load) begin
      active_r <= 1'b1;
      shift_r  <= byte_in;
      baud_r   <= {CNT_W{1'b0}};
      bit_r    <= 4'd0;
      tx_r     <= 1'b0;
    end else if (active_r) begin
      if (baud_r == CNT_LAST) begin
        baud_r <= {CNT_W{1'b0}};
        if (bit_r == STOP_BIT) begin
          active_r <= 1'b0;
          bit_r    <= 4'd0;
          tx_r     <= 1'b1;
        end else begin
          bit_r <= bit_r + 4'd1;
          if (bit_r == 4'd8) begin
            tx_r <= 1'b1;
          end else begin
            tx_r    <= shift_r[0];
            shift_r <= {1'b1, shift_r[7:1]};
          end
        end
      end else begin
        baud_r <= baud_r + CNT_W'(1);
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

endmodule

// File: rtl/bcd12_uart_tx.sv
// 3-digit BCD to ASCII UART transmitter, hundreds digit first, frames back to back.
// Optional feature: define BCD_TX_CRLF_EN to append CR LF after the units digit.
module bcd12_uart_tx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] data12,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  import bcd_uart_pkg::*;

`ifdef BCD_TX_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd2;
`endif

  tx_state_e   state_r, state_s;
  logic [11:0] hold_r, hold_s;
  logic [2:0]  byte_idx_r, byte_idx_s;
  logic        pend_r, pend_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        load_s;
  logic [2:0]  sel_s;
  logic [7:0]  load_byte_s;
  logic        frame_done_s;

  assign busy = busy_r;
  assign done = done_r;

  // Message state register; pend_r defers the first load by one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      hold_r     <= 12'h000;
      byte_idx_r <= 3'd0;
      pend_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_r     <= hold_s;
      byte_idx_r <= byte_idx_s;
      pend_r     <= pend_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Message FSM: DONE behaves like IDLE for acceptance so messages can run back to back.
  always_comb begin
    state_s    = state_r;
    hold_s     = hold_r;
    byte_idx_s = byte_idx_r;
    pend_s     = pend_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    load_s     = 1'b0;
    sel_s      = byte_idx_r;
    case (state_r)
      IDLE, DONE: begin
        busy_s = 1'b0;
        if (start) begin
          state_s    = SEND;
          hold_s     = data12;
          byte_idx_s = 3'd0;
          pend_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (pend_r) begin
          load_s = 1'b1;
          sel_s  = 3'd0;
          pend_s = 1'b0;
          busy_s = 1'b1;
        end else if (frame_done_s) begin
          if (byte_idx_r == LAST_IDX) begin
            state_s    = DONE;
            done_s     = 1'b1;
            busy_s     = 1'b0;
            byte_idx_s = 3'd0;
          end else begin
            byte_idx_s = byte_idx_r + 3'd1;
            sel_s      = byte_idx_r + 3'd1;
            load_s     = 1'b1;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        byte_idx_s = 3'd0;
        pend_s     = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Byte mux: digits from the captured value, then the optional terminator.
  always_comb begin
    load_byte_s = ASCII_ERR;
    case (sel_s)
      3'd0:    load_byte_s = digit_to_ascii(hold_r[11:8]);
      3'd1:    load_byte_s = digit_to_ascii(hold_r[7:4]);
      3'd2:    load_byte_s = digit_to_ascii(hold_r[3:0]);
`ifdef BCD_TX_CRLF_EN
      3'd3:    load_byte_s = ASCII_CR;
      3'd4:    load_byte_s = ASCII_LF;
`endif
      default: load_byte_s = ASCII_ERR;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .byte_in    (load_byte_s),
    .tx         (tx),
    .frame_done (frame_done_s)
  );

endmodule

// File: tb/tb_bcd12_uart_tx.sv
// Self-checking bench for bcd12_uart_tx: decodes the serial line sample by sample and
// compares bytes, framing and done/busy timing against an arithmetic message model.
module tb_bcd12_uart_tx;

  localparam int CPB = 16;
`ifdef BCD_TX_CRLF_EN
  localparam int N = 5;
`else
  localparam int N = 3;
`endif
  localparam int L = N * 10 * CPB;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] data12;
  logic        tx;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;
  logic line_q [0:5*10*CPB];

  typedef struct {
    logic [11:0] data;
    logic [23:0] digits;
  } vec_t;

  vec_t tab [5];

  bcd12_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data12  (data12),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference message: digit bytes from decimal arithmetic, then CR LF when enabled.
  function automatic logic [39:0] model_msg(input logic [11:0] d);
    logic [39:0] m;
    int nib;
    m = 40'h0;
    for (int j = 0; j < 3; j++) begin
      nib = (int'(d) / (1 << (4 * (2 - j)))) % 16;
      m[39 - 8*j -: 8] = (nib < 10) ? 8'(48 + nib) : 8'(63);
    end
    m[15:8] = 8'h0D;
    m[7:0]  = 8'h0A;
    return m;
  endfunction

  task automatic start_msg(input logic [11:0] d, input logic keep, input logic [11:0] d_next);
    @(negedge clk);
    data12 = d;
    start  = 1'b1;
    @(negedge clk);
    data12 = d_next;
    start  = keep;
    check("accept_latency", {30'd0, tx, busy}, 32'h2);
  endtask

  // Called at the negedge right after acceptance; returns at the negedge of the done cycle.
  task automatic capture(input logic [39:0] exp, input string tag);
    int pulses;
    int done_at;
    int base;
    logic [7:0] b;
    logic framing;
    pulses  = 0;
    done_at = -1;
    @(negedge clk);
    check({tag, "_first_fall"}, {30'd0, tx, busy}, 32'h1);
    for (int c = 0; c <= L; c++) begin
      if (c > 0) @(negedge clk);
      line_q[c] = tx;
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
    end
    check({tag, "_done_at"}, done_at, L);
    check({tag, "_done_pulses"}, pulses, 1);
    check({tag, "_end_state"}, {30'd0, tx, busy}, 32'h2);
    for (int j = 0; j < N; j++) begin
      base = j * 10 * CPB + CPB / 2;
      b = 8'h00;
      for (int k = 1; k <= 8; k++) b[k-1] = line_q[base + k * CPB];
      framing = (line_q[base] == 1'b0) && (line_q[base + 9 * CPB] == 1'b1);
      check($sformatf("%s_byte%0d", tag, j), {24'd0, b}, {24'd0, exp[39 - 8*j -: 8]});
      check($sformatf("%s_frame%0d", tag, j), {31'd0, framing}, 32'h1);
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_single"}, {31'd0, done}, 32'h0);
  endtask

  initial begin
    logic [11:0] d;
    logic        bad;
    vectors     = 0;
    miscompares = 0;
    tab[0] = '{12'h123, 24'h313233};
    tab[1] = '{12'h9A0, 24'h393F30};
    tab[2] = '{12'hFFF, 24'h3F3F3F};
    tab[3] = '{12'h000, 24'h303030};
    tab[4] = '{12'h9B8, 24'h393F38};

    // Reset, with start held high to show reset wins.
    reset_n = 1'b0;
    start   = 1'b1;
    data12  = 12'h123;
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, tx, busy, done}, 32'h4);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {29'd0, tx, busy, done}, 32'h4);

    // Table vectors with hand-derived expected bytes.
    for (int i = 0; i < 5; i++) begin
      start_msg(tab[i].data, 1'b0, ~tab[i].data);
      capture({tab[i].digits, 8'h0D, 8'h0A}, $sformatf("tab%0d", i));
      after_done($sformatf("tab%0d", i));
    end

    // Randomised values against the model.
    for (int i = 0; i < 6; i++) begin
      d = 12'($urandom_range(0, 4095));
      start_msg(d, 1'b0, 12'($urandom_range(0, 4095)));
      capture(model_msg(d), $sformatf("rnd%0d", i));
      after_done($sformatf("rnd%0d", i));
    end

    // Start while busy is ignored and not queued.
    start_msg(12'h123, 1'b0, 12'h456);
    fork
      capture(model_msg(12'h123), "ignore");
      begin
        repeat (100) @(negedge clk);
        data12 = 12'h777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
      end
    join
    after_done("ignore");
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    check("ignore_not_queued", {31'd0, bad}, 32'h0);

    // Reset in the middle of the second byte abandons the message.
    start_msg(12'h456, 1'b0, 12'h000);
    repeat (10 * CPB + 40) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_line", {30'd0, tx, busy}, 32'h2);
    bad = 1'b0;
    repeat (L + 20) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("midreset_quiet", {31'd0, bad}, 32'h0);
    start_msg(12'h305, 1'b0, 12'h999);
    capture(model_msg(12'h305), "after_reset");
    after_done("after_reset");

    // start held across done: second message is accepted in the done cycle.
    start_msg(12'h123, 1'b1, 12'h864);
    capture(model_msg(12'h123), "b2b_first");
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", {30'd0, tx, busy}, 32'h2);
    capture(model_msg(12'h864), "b2b_second");
    after_done("b2b_second");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
